// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fills a small word buffer from instruction memory,
// extracts the instruction at the architectural PC and registers {pc, instr}
// for the decoder. Honours decoder stall and jump redirects.
// Optional compressed-parcel support is enabled by defining FETCH_RVC_EN.

package PipelineReg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } ID_STATE;
endpackage

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          FB_DEPTH  = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                jmp,
    input  logic [31:0]         jmp_pc,
    output PipelineReg::ID_STATE id_state,
    output logic                id_valid,
    output logic                id_rvc
);

    localparam int PTR_W = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam int CNT_W = $clog2(FB_DEPTH + 1);

    // Fetch buffer storage (small, read asynchronously at the head)
    logic [31:0]      fb_mem [FB_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] fetch_addr;
    logic [31:0] issue_pc;
    logic        inflight;
    logic        inflight_epoch;
    logic        epoch;

    logic [31:0] head_word;
    logic        can_issue;
    logic        issue_pop;
    logic        issue_rvc;
    logic [31:0] issue_instr;
    logic [31:0] issue_inc;
    logic        issue_fire;
    logic        pop_fire;
    logic        resp_ok;
    logic [CNT_W:0] occupancy;
    logic [31:0] redirect_pc;
    logic [1:0]  unused_jmp_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_word       = fb_mem[rd_ptr];
    assign unused_jmp_bits = jmp_pc[1:0];

`ifdef FETCH_RVC_EN
    logic [31:0] next_word;
    logic [15:0] parcel;
    assign next_word   = fb_mem[ptr_inc(rd_ptr)];
    assign parcel      = issue_pc[1] ? head_word[31:16] : head_word[15:0];
    assign redirect_pc = {jmp_pc[31:1], 1'b0};
`else
    assign redirect_pc = {jmp_pc[31:2], 2'b00};
`endif

    // Decide whether a complete instruction sits at issue_pc and how to consume it
    always_comb begin
        can_issue   = 1'b0;
        issue_pop   = 1'b0;
        issue_rvc   = 1'b0;
        issue_instr = NOP_INSTR;
        issue_inc   = 32'd4;
`ifdef FETCH_RVC_EN
        if (parcel[1:0] != 2'b11) begin
            // 16-bit parcel: the word is done once its upper parcel is used
            can_issue   = (count != '0);
            issue_instr = {16'h0000, parcel};
            issue_rvc   = 1'b1;
            issue_inc   = 32'd2;
            issue_pop   = issue_pc[1];
        end else if (!issue_pc[1]) begin
            can_issue   = (count != '0);
            issue_instr = head_word;
            issue_pop   = 1'b1;
        end else begin
            // 32-bit instruction straddling two words
            can_issue   = (count >= CNT_W'(2));
            issue_instr = {next_word[15:0], head_word[31:16]};
            issue_pop   = 1'b1;
        end
`else
        can_issue   = (count != '0);
        issue_instr = head_word;
        issue_pop   = 1'b1;
`endif
    end

    assign issue_fire = can_issue && !stall && !jmp;
    assign pop_fire   = issue_fire && issue_pop;
    assign resp_ok    = inflight && (inflight_epoch == epoch) && !jmp;

    // Occupancy counts this cycle's pop so the buffer streams at one word per cycle
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop_fire};
    assign imem_req  = reset && !jmp && (occupancy < (CNT_W + 1)'(FB_DEPTH));
    assign imem_addr = fetch_addr;

    // Buffer data array: written on accepted responses, no reset needed
    always_ff @(posedge clk) begin
        if (resp_ok) begin
            fb_mem[wr_ptr] <= imem_rdata;
        end
    end

    // Fetch control, buffer bookkeeping and the registered decode interface
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_addr           <= RESET_PC;
            issue_pc             <= RESET_PC;
            rd_ptr               <= '0;
            wr_ptr               <= '0;
            count                <= '0;
            inflight             <= 1'b0;
            inflight_epoch       <= 1'b0;
            epoch                <= 1'b0;
            id_state.pc          <= 32'h0;
            id_state.instruction <= NOP_INSTR;
            id_valid             <= 1'b0;
            id_rvc               <= 1'b0;
        end else begin
            inflight       <= imem_req;
            inflight_epoch <= epoch;
            if (jmp) begin
                epoch                <= ~epoch;
                rd_ptr               <= '0;
                wr_ptr               <= '0;
                count                <= '0;
                fetch_addr           <= {jmp_pc[31:2], 2'b00};
                issue_pc             <= redirect_pc;
                id_state.instruction <= NOP_INSTR;
                id_valid             <= 1'b0;
                id_rvc               <= 1'b0;
            end else begin
                if (imem_req) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
                if (resp_ok) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop_fire) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                count <= count + {{(CNT_W-1){1'b0}}, resp_ok} - {{(CNT_W-1){1'b0}}, pop_fire};
                if (!stall) begin
                    if (issue_fire) begin
                        id_state.pc          <= issue_pc;
                        id_state.instruction <= issue_instr;
                        id_valid             <= 1'b1;
                        id_rvc               <= issue_rvc;
                        issue_pc             <= issue_pc + issue_inc;
                    end else begin
                        id_state.instruction <= NOP_INSTR;
                        id_valid             <= 1'b0;
                        id_rvc               <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
